// File: rtl/ioctl_pkg.sv
// rtl/ioctl_pkg.sv - shared ioctl bus widths, upload FSM state type and helpers
package ioctl_pkg;

  localparam int IOCTL_ADDR_W = 25;
  localparam int IOCTL_DATA_W = 8;

  typedef enum logic [1:0] {
    UPL_IDLE = 2'd0,
    UPL_ARB  = 2'd1,
    UPL_LAT  = 2'd2
  } upl_state_t;

  function automatic logic [IOCTL_ADDR_W-1:0] sat_inc(input logic [IOCTL_ADDR_W-1:0] v);
    return (&v) ? v : v + IOCTL_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ioctl_cycle_timer.sv
// rtl/ioctl_cycle_timer.sv - loadable down-counter; flags the last cycle of a loaded interval
module ioctl_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of N means the N-th following cycle is the expiry cycle
  assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/ioctl_upload_reader.sv
// rtl/ioctl_upload_reader.sv - serves HPS upload reads from an arbitrated core RAM read port
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter int         AW        = 14,
  parameter int         MEM_BYTES = 16384,
  parameter logic [7:0] INDEX     = 8'd1,
  parameter int         RD_LAT    = 1,
  parameter int         GNT_TO    = 255,
  parameter logic [7:0] FILL      = 8'hFF
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_upload,
  input  logic                    ioctl_rd,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_index,
  output logic [IOCTL_DATA_W-1:0] ioctl_din,
  output logic                    ioctl_wait,
  output logic                    mem_req,
  output logic [AW-1:0]           mem_addr,
  input  logic                    mem_gnt,
  input  logic [7:0]              mem_data,
  output logic [IOCTL_ADDR_W-1:0] byte_count,
  output logic                    upload_done,
  output logic                    err_timeout,
  output logic                    err_overrun
);

  localparam logic [IOCTL_ADDR_W-1:0] MEM_LIMIT = IOCTL_ADDR_W'(MEM_BYTES);
  localparam logic [7:0]              GNT_TO_V  = 8'(GNT_TO);
  localparam logic [7:0]              RD_LAT_V  = 8'(RD_LAT);

  upl_state_t state_q, state_d;

  logic                    active, active_q, rise, fall, abort;
  logic                    rd_hit, out_of_range, accept, grant_take;
  logic                    timer_expired, timeout_ev, lat_done, fill_ev;
  logic [7:0]              din_q, din_d;
  logic [AW-1:0]           mem_addr_q, mem_addr_d;
  logic [IOCTL_ADDR_W-1:0] count_q, count_d;
  logic                    done_q, err_to_q, err_to_d, err_ov_q, err_ov_d;

  assign active       = ioctl_upload && (ioctl_index == INDEX);
  assign rise         = active && !active_q;
  assign fall         = !active && active_q;
  assign abort        = !active && (state_q != UPL_IDLE);
  assign rd_hit       = ioctl_rd && active;
  assign out_of_range = (ioctl_addr >= MEM_LIMIT);
  assign accept       = (state_q == UPL_IDLE) && rd_hit && !out_of_range;
  assign grant_take   = (state_q == UPL_ARB) && !abort && mem_gnt;
  assign timeout_ev   = (state_q == UPL_ARB) && !abort && !mem_gnt && timer_expired;
  assign lat_done     = (state_q == UPL_LAT) && !abort && timer_expired;
  assign fill_ev      = ((state_q == UPL_IDLE) && rd_hit && out_of_range) || timeout_ev;

  // One timer serves both the grant timeout in ARB and the read latency in LAT
  ioctl_cycle_timer #(.W(8)) u_timer (
    .clk_i      (clk_sys),
    .rst_ni     (reset_n),
    .load_i     (accept || grant_take),
    .load_val_i (accept ? GNT_TO_V : RD_LAT_V),
    .en_i       (state_q != UPL_IDLE),
    .expired_o  (timer_expired)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UPL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UPL_IDLE: if (accept) state_d = UPL_ARB;
      UPL_ARB: begin
        if (abort)              state_d = UPL_IDLE;
        else if (mem_gnt)       state_d = UPL_LAT;
        else if (timer_expired) state_d = UPL_IDLE;
      end
      UPL_LAT: if (abort || timer_expired) state_d = UPL_IDLE;
      default: state_d = UPL_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == UPL_ARB);
    ioctl_wait = (state_q != UPL_IDLE);
  end

  always_comb begin
    din_d      = din_q;
    mem_addr_d = mem_addr_q;
    count_d    = rise ? '0 : count_q;
    err_to_d   = rise ? 1'b0 : err_to_q;
    err_ov_d   = rise ? 1'b0 : err_ov_q;
    if (fill_ev)  din_d = FILL;
    if (lat_done) din_d = mem_data;
    if (accept)   mem_addr_d = ioctl_addr[AW-1:0];
    if (fill_ev || lat_done) count_d = sat_inc(count_d);
    if (timeout_ev) err_to_d = 1'b1;
    if (rd_hit && state_q != UPL_IDLE) err_ov_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      active_q   <= 1'b0;
      din_q      <= 8'h00;
      mem_addr_q <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      active_q   <= active;
      din_q      <= din_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      done_q     <= fall;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
    end
  end

  assign ioctl_din   = din_q;
  assign mem_addr    = mem_addr_q;
  assign byte_count  = count_q;
  assign upload_done = done_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb/tb_ioctl_upload_reader.sv - self-checking bench for ioctl_upload_reader
module tb_ioctl_upload_reader;

  localparam int          AW        = 14;
  localparam int          MEM_BYTES = 16384;
  localparam int          RD_LAT    = 1;
  localparam int          GNT_TO    = 255;
  localparam logic [7:0]  FILL      = 8'hFF;
  localparam logic [24:0] MEM_LIM   = 25'd16384;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload, ioctl_rd, mem_gnt;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_index;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait, mem_req;
  logic [AW-1:0] mem_addr;
  logic [7:0]  mem_data;
  logic [24:0] byte_count;
  logic        upload_done, err_timeout, err_overrun;

  ioctl_upload_reader #(
    .AW(AW), .MEM_BYTES(MEM_BYTES), .INDEX(8'd1), .RD_LAT(RD_LAT), .GNT_TO(GNT_TO), .FILL(FILL)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_data(mem_data), .byte_count(byte_count), .upload_done(upload_done),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] ram [0:MEM_BYTES-1];

  // RAM model: data appears RD_LAT(=1) cycle after the grant cycle, junk otherwise
  initial mem_data = 8'h00;
  always @(posedge clk_sys) mem_data <= mem_gnt ? ram[mem_addr] : 8'hC3;

  int n_vec = 0;
  int n_err = 0;
  int wait_cnt = 0;
  bit chk_en = 1'b0;

  logic [7:0]    exp_din;
  logic          exp_wait, exp_req, exp_done, exp_to, exp_ovr;
  logic [AW-1:0] exp_addr;
  logic [24:0]   exp_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk_sys) begin
    if (ioctl_wait) wait_cnt++;
    if (chk_en) begin
      chk("din", 32'(ioctl_din), 32'(exp_din));
      chk("wait", 32'(ioctl_wait), 32'(exp_wait));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("byte_count", 32'(byte_count), 32'(exp_count));
      chk("upload_done", 32'(upload_done), 32'(exp_done));
      chk("err_timeout", 32'(err_timeout), 32'(exp_to));
      chk("err_overrun", 32'(err_overrun), 32'(exp_ovr));
    end
  end

  function automatic logic [24:0] sat(input logic [24:0] v);
    return (v == 25'h1FFFFFF) ? v : v + 25'd1;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_exp();
    exp_din = 8'h00; exp_wait = 0; exp_req = 0; exp_done = 0;
    exp_to = 0; exp_ovr = 0; exp_addr = '0; exp_count = '0;
  endtask

  task automatic start_upload();
    ioctl_index = 8'd1; ioctl_upload = 1'b1;
    step();
    exp_count = '0; exp_to = 0; exp_ovr = 0;
  endtask

  task automatic end_upload();
    ioctl_upload = 1'b0;
    step(); exp_done = 1;
    step(); exp_done = 0;
  endtask

  // d = grant delay after the first request cycle (<0: never); ko = cycle of an extra rd (<0: none)
  task automatic do_read(input logic [24:0] addr, input int d, input int ko);
    int g, last;
    g = (d < 0) ? -1 : d + 1;
    ioctl_addr = addr; ioctl_rd = 1'b1;
    if (addr >= MEM_LIM) begin
      step(); ioctl_rd = 1'b0;
      exp_din = FILL; exp_count = sat(exp_count);
      return;
    end
    last = (g < 0) ? GNT_TO : g + RD_LAT;
    for (int k = 1; k <= last + 1; k++) begin
      step();
      ioctl_rd = (k == ko);
      mem_gnt  = (k == g);
      if (k == ko) ioctl_addr = addr + 25'd1;
      if (ko >= 1 && k == ko + 1) exp_ovr = 1;
      if (k <= last) begin
        exp_wait = 1;
        exp_req  = (g < 0) || (k <= g);
        exp_addr = addr[AW-1:0];
      end else begin
        exp_wait = 0; exp_req = 0;
        exp_din = (g < 0) ? FILL : ram[addr[AW-1:0]];
        exp_count = sat(exp_count);
        if (g < 0) exp_to = 1;
      end
    end
  endtask

  task automatic do_abort(input logic [24:0] addr);
    ioctl_addr = addr; ioctl_rd = 1'b1;
    step(); ioctl_rd = 1'b0;
    exp_wait = 1; exp_req = 1; exp_addr = addr[AW-1:0];
    step(); ioctl_upload = 1'b0; mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
    exp_wait = 0; exp_req = 0; exp_done = 1;
    step(); exp_done = 0;
    step();
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ram[i] = 8'(i) ^ 8'(i >> 6) ^ 8'h5C;
    ram[16'h0010] = 8'hA5;
    reset_n = 1'b0; ioctl_upload = 0; ioctl_rd = 0; mem_gnt = 0;
    ioctl_addr = '0; ioctl_index = 8'd1;
    clear_exp();
    step(); step(); step();
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_count", 32'(byte_count), 32'h0);
    chk("rst_flags", 32'({upload_done, err_timeout, err_overrun}), 32'h0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    start_upload();

    wait_cnt = 0;
    do_read(25'h0010, 0, -1);
    chk("t2_din", 32'(ioctl_din), 32'hA5);
    chk("t2_count", 32'(byte_count), 32'd1);
    chk("t2_wait_len", 32'(wait_cnt), 32'd2);

    // reset asserted mid-LAT acts at once
    ioctl_addr = 25'h0020; ioctl_rd = 1'b1;
    step(); ioctl_rd = 1'b0; mem_gnt = 1'b1;
    exp_wait = 1; exp_req = 1; exp_addr = 14'h0020;
    step(); mem_gnt = 1'b0; exp_req = 0;
    #1; chk_en = 1'b0; reset_n = 1'b0; #1;
    chk("t1_din", 32'(ioctl_din), 32'h00);
    chk("t1_wait", 32'(ioctl_wait), 32'h0);
    chk("t1_req", 32'(mem_req), 32'h0);
    chk("t1_count", 32'(byte_count), 32'h0);
    chk("t1_flags", 32'({upload_done, err_timeout, err_overrun}), 32'h0);
    clear_exp();
    step(); step(); reset_n = 1'b1;
    step(); chk_en = 1'b1;

    wait_cnt = 0;
    do_read(25'h0123, 10, -1);
    chk("t3_stall_wait_len", 32'(wait_cnt), 32'd12);
    wait_cnt = 0;
    do_read(25'h0200, -1, -1);
    chk("t3_timeout_flag", 32'(err_timeout), 32'h1);
    chk("t3_timeout_din", 32'(ioctl_din), 32'hFF);
    chk("t3_timeout_wait_len", 32'(wait_cnt), 32'd255);

    wait_cnt = 0;
    do_read(25'h0004000, 0, -1);
    step();
    do_read(25'h1FFFFFF, 0, -1);
    step();
    chk("t4_wait_len", 32'(wait_cnt), 32'd0);

    do_read(25'h0055, 3, 2);
    chk("t5_overrun", 32'(err_overrun), 32'h1);
    do_read(25'h0066, 0, 1);
    end_upload();

    ioctl_index = 8'd2; ioctl_upload = 1'b1;
    step(); ioctl_addr = 25'h0030; ioctl_rd = 1'b1;
    step(); ioctl_rd = 1'b0;
    for (int i = 0; i < 4; i++) step();
    ioctl_upload = 1'b0;
    step();

    start_upload();
    chk("t6_cleared", 32'({byte_count, err_timeout, err_overrun}), 32'h0);
    do_read(25'h0077, 0, -1);
    wait_cnt = 0;
    do_abort(25'h0080);
    chk("t6_abort_wait_len", 32'(wait_cnt), 32'd2);

    start_upload();
    for (int a = 0; a < 256; a++) do_read(25'(a), a % 3, -1);
    chk("t6_dump_count", 32'(byte_count), 32'd256);
    end_upload();
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
